mannix_ddr_rd_resp: RTL
=======================

Name: mannix_ddr_rd_resp

Overview:
- DDR-side responder for the mem-farm read request channel (mem_req / mem_start_addr / mem_data / mem_valid).
- Accepts one read request at a time.
- Fetches the requested bytes as 256-bit lines from a backing-memory port, then streams them back in order, one line per beat.
- Each response carries last-beat and last-valid-byte-count indications, so the farm's demux can place data into SRAM without a ready signal.

Parameters:
- DATA_W, 256, data beat width in bits (32 bytes).
- ADDR_W, 32, byte address width.
- LEN_W, 16, request length field width (bytes).
- MAX_OUT, 4, maximum backing-memory reads outstanding.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  in  1  read request strobe, single cycle.
- mem_start_addr  in  ADDR_W  request byte address; bits [4:0] ignored (line aligned).
- mem_size_bytes  in  LEN_W  request length in bytes.
- mem_busy  out  1  request in progress; mem_req ignored while high.
- mem_data  out  DATA_W  response beat.
- mem_valid  out  1  mem_data valid this cycle.
- mem_last  out  1  final beat of the response.
- mem_num_of_last_valid  out  5  valid bytes in the final beat; 0 means 32. Meaningful only with mem_last.
- bk_rd_en  out  1  backing read request.
- bk_addr  out  ADDR_W-5  backing line address.
- bk_gnt  in  1  backing accepted bk_rd_en this cycle.
- bk_rdata  in  DATA_W  backing read data, returned in order.
- bk_rvalid  in  1  bk_rdata valid.

Behaviour:
- Reset: all outputs 0. State IDLE. All counters 0. Reset mid-burst aborts the burst; no further mem_valid until a new request.
- Length: beats = ceil(mem_size_bytes/32), computed LEN_W-5+1 wide.
- Request capture: mem_req in IDLE with mem_size_bytes != 0 latches the following and goes to ISSUE; mem_busy rises the next cycle:
  - line address = mem_start_addr[ADDR_W-1:5]
  - beats
  - last_valid = mem_size_bytes[4:0]
- Ignored requests:
  - mem_req with size 0 is ignored; state and outputs unchanged.
  - mem_req while busy is ignored.
- ISSUE state:
  - bk_rd_en = 1 when outstanding < MAX_OUT.
  - bk_addr = base + issued_count.
  - On bk_gnt: issued_count++ and outstanding++.
  - When issued_count reaches beats: bk_rd_en drops in the same cycle as the last grant is taken; go to WAIT.
- Outstanding counter:
  - bk_rvalid decrements it.
  - A simultaneous grant and rvalid leave it unchanged.
- Line address wrap: above 2^(ADDR_W-5)-1 the address wraps modulo the width, with no error.
- WAIT state: remain until returned_count == beats, then go to IDLE. mem_busy falls the cycle after the final mem_valid.
- Response path, while in ISSUE or WAIT:
  - bk_rvalid is registered; mem_valid is asserted exactly 1 cycle after bk_rvalid.
  - mem_data = registered bk_rdata.
  - returned_count++ per beat.
  - mem_last = 1 on beat number beats; mem_num_of_last_valid = last_valid on that beat, 0 otherwise.
- Spurious data: bk_rvalid in IDLE is dropped, with no mem_valid.
- Single-beat request: mem_valid and mem_last are asserted in the same cycle.
- Throughput: with bk_gnt tied high and fixed backing latency, one beat per cycle is sustained.

Optional Feature:
- Macro MANNIX_DDR_RD_RESP_MASK_EN.
- Defined: on the last beat with last_valid != 0, bytes [31:last_valid] of mem_data are forced to 0x00; other beats pass unchanged.
- Undefined: mem_data always equals the registered bk_rdata, and the mask logic is absent.

Test Plan:
- Basic request:
  - Stimulus: mem_req, addr 0x0000_1040, size 96, bk_gnt=1, backing latency 2.
  - Response: bk_addr 0x82, 0x83, 0x84 on consecutive cycles; three mem_valid beats in order; mem_last on beat 3 with mem_num_of_last_valid 0; mem_busy low the cycle after.
- Partial last beat:
  - Stimulus: size 45, backing data 0xAA…, MASK_EN defined.
  - Response: 2 beats; last beat has mem_num_of_last_valid 13, bytes 13..31 = 0x00.
  - Repeat without MASK_EN: last beat is all 0xAA.
- Backpressure / credit limit:
  - Stimulus: size 320 (10 beats); bk_gnt toggling; backing latency 8; MAX_OUT 4.
  - Response: outstanding never exceeds 4; 10 beats in order; mem_last only on the 10th.
- Ignored requests:
  - Stimulus: mem_req with size 0 in IDLE, then a second mem_req while busy.
  - Response: no bk_rd_en for the first; the second is ignored and only the first valid request's beats appear.
- Reset mid-operation:
  - Stimulus: rst_n low after 2 of 8 beats; then a new request of size 32.
  - Response: all outputs 0 during reset; stale bk_rvalid after reset dropped; new request produces exactly 1 beat with mem_last=1.
- Spurious return and address wrap:
  - Stimulus: bk_rvalid pulse in IDLE, then addr 0xFFFF_FFE0 with size 64.
  - Response: no mem_valid from the spurious pulse; bk_addr 0x7FF_FFFF then 0x000_0000; 2 beats.

Source files
------------

// File: rtl/mannix_ddr_rd_resp.sv
// mannix_ddr_rd_resp: DDR-side read responder for the mem-farm request channel.
// Accepts one line-aligned read request at a time. It issues backing-memory line
// reads while keeping at most MAX_OUT reads outstanding. It then streams the
// returned lines back in order, with last-beat and last-valid-byte-count markers,
// so the farm demux can place data without a ready handshake.
// Optional build macro: MANNIX_DDR_RD_RESP_MASK_EN zeroes the unused tail bytes of
// the final beat.
module mannix_ddr_rd_resp #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_start_addr,
    input  logic [LEN_W-1:0]  mem_size_bytes,
    output logic              mem_busy,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_valid,
    output logic              mem_last,
    output logic [4:0]        mem_num_of_last_valid,
    output logic              bk_rd_en,
    output logic [ADDR_W-6:0] bk_addr,
    input  logic              bk_gnt,
    input  logic [DATA_W-1:0] bk_rdata,
    input  logic              bk_rvalid
);

    localparam int LINE_W = ADDR_W - 5;
    localparam int BEAT_W = LEN_W - 5 + 1;
    localparam int OUT_W  = $clog2(MAX_OUT + 1);

    localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]  OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LINE_W-1:0] base_q, base_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [4:0]        last_valid_q, last_valid_d;
    logic [BEAT_W-1:0] issued_q, issued_d;
    logic [BEAT_W-1:0] returned_q, returned_d;
    logic [OUT_W-1:0]  out_q, out_d;

    logic              mem_busy_q, mem_busy_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_last_q, mem_last_d;
    logic [4:0]        mem_nlv_q, mem_nlv_d;
    logic              bk_rd_en_q, bk_rd_en_d;
    logic [LINE_W-1:0] bk_addr_q, bk_addr_d;

    logic              take_s;
    logic              resp_s;
    logic              final_beat_s;
    logic [BEAT_W-1:0] req_beats_s;

    // Byte offset within a line is dropped: requests are line aligned.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^mem_start_addr[4:0];

`ifdef MANNIX_DDR_RD_RESP_MASK_EN
    // Keep bytes below n, clear bytes n and above.
    function automatic logic [DATA_W-1:0] mask_tail(input logic [DATA_W-1:0] d,
                                                    input logic [4:0]        n);
        logic [DATA_W-1:0] r;
        r = d;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (i >= int'(n)) begin
                r[i*8 +: 8] = 8'h00;
            end else begin
                r[i*8 +: 8] = d[i*8 +: 8];
            end
        end
        return r;
    endfunction
`endif

    // Next-state, counters, and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        beats_d      = beats_q;
        last_valid_d = last_valid_q;
        issued_d     = issued_q;
        returned_d   = returned_q;
        out_d        = out_q;

        req_beats_s  = {1'b0, mem_size_bytes[LEN_W-1:5]} +
                       {{(BEAT_W-1){1'b0}}, |mem_size_bytes[4:0]};
        take_s       = (state_q == S_ISSUE) && bk_rd_en_q && bk_gnt;
        // Returns are only accepted while a burst is active and still owed data.
        resp_s       = (state_q != S_IDLE) && bk_rvalid && (returned_q != beats_q);
        final_beat_s = ((returned_q + BEAT_ONE) == beats_q);

        case (state_q)
            S_IDLE: begin
                if (mem_req && (mem_size_bytes != {LEN_W{1'b0}})) begin
                    base_d       = mem_start_addr[ADDR_W-1:5];
                    beats_d      = req_beats_s;
                    last_valid_d = mem_size_bytes[4:0];
                    issued_d     = {BEAT_W{1'b0}};
                    returned_d   = {BEAT_W{1'b0}};
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (take_s) begin
                    issued_d = issued_q + BEAT_ONE;
                    if (issued_d == beats_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                // returned_q reaches beats on the cycle the final beat is presented,
                // so busy drops one cycle after the final mem_valid.
                if (returned_q == beats_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_s) begin
            returned_d = returned_q + BEAT_ONE;
        end else begin
            returned_d = returned_d;
        end

        case ({take_s, resp_s})
            2'b10:   out_d = out_q + OUT_ONE;
            2'b01:   out_d = (out_q != {OUT_W{1'b0}}) ? (out_q - OUT_ONE) : out_q;
            default: out_d = out_q;
        endcase

        // Read enable looks at the post-update credit count, so a grant never
        // pushes outstanding reads past MAX_OUT.
        bk_rd_en_d = (state_d == S_ISSUE) && (out_d < OUT_MAX);
        if (state_d == S_ISSUE) begin
            bk_addr_d = base_d + {{(LINE_W-BEAT_W){1'b0}}, issued_d};
        end else begin
            bk_addr_d = {LINE_W{1'b0}};
        end

        mem_busy_d  = (state_d != S_IDLE);
        mem_valid_d = resp_s;
        mem_last_d  = resp_s && final_beat_s;
        if (resp_s && final_beat_s) begin
            mem_nlv_d = last_valid_q;
        end else begin
            mem_nlv_d = 5'd0;
        end

        if (resp_s) begin
`ifdef MANNIX_DDR_RD_RESP_MASK_EN
            if (final_beat_s && (last_valid_q != 5'd0)) begin
                mem_data_d = mask_tail(bk_rdata, last_valid_q);
            end else begin
                mem_data_d = bk_rdata;
            end
`else
            mem_data_d = bk_rdata;
`endif
        end else begin
            mem_data_d = mem_data_q;
        end
    end

    // State, counters and output registers; an async reset aborts any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= {LINE_W{1'b0}};
            beats_q      <= {BEAT_W{1'b0}};
            last_valid_q <= 5'd0;
            issued_q     <= {BEAT_W{1'b0}};
            returned_q   <= {BEAT_W{1'b0}};
            out_q        <= {OUT_W{1'b0}};
            mem_busy_q   <= 1'b0;
            mem_data_q   <= {DATA_W{1'b0}};
            mem_valid_q  <= 1'b0;
            mem_last_q   <= 1'b0;
            mem_nlv_q    <= 5'd0;
            bk_rd_en_q   <= 1'b0;
            bk_addr_q    <= {LINE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            beats_q      <= beats_d;
            last_valid_q <= last_valid_d;
            issued_q     <= issued_d;
            returned_q   <= returned_d;
            out_q        <= out_d;
            mem_busy_q   <= mem_busy_d;
            mem_data_q   <= mem_data_d;
            mem_valid_q  <= mem_valid_d;
            mem_last_q   <= mem_last_d;
            mem_nlv_q    <= mem_nlv_d;
            bk_rd_en_q   <= bk_rd_en_d;
            bk_addr_q    <= bk_addr_d;
        end
    end

    assign mem_busy              = mem_busy_q;
    assign mem_data              = mem_data_q;
    assign mem_valid             = mem_valid_q;
    assign mem_last              = mem_last_q;
    assign mem_num_of_last_valid = mem_nlv_q;
    assign bk_rd_en              = bk_rd_en_q;
    assign bk_addr               = bk_addr_q;

endmodule
